// File: rtl/avl_arbiter_2m.sv
// Two-master to one-slave Avalon-MM arbiter with a registered IDLE/GNT0/GNT1 grant FSM.
// Optional stall watchdog enabled by defining AVL_ARB_TIMEOUT_EN.
module avl_arbiter_2m #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
  input  logic [DATA_WIDTH-1:0]   m0_writedata,
  input  logic                    m0_read,
  input  logic                    m0_write,
  output logic [DATA_WIDTH-1:0]   m0_readdata,
  output logic                    m0_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
  input  logic [DATA_WIDTH-1:0]   m1_writedata,
  input  logic                    m1_read,
  input  logic                    m1_write,
  output logic [DATA_WIDTH-1:0]   m1_readdata,
  output logic                    m1_waitrequest,
  output logic [ADDR_WIDTH-1:0]   s_address,
  output logic [DATA_WIDTH/8-1:0] s_byteenable,
  output logic [DATA_WIDTH-1:0]   s_writedata,
  output logic                    s_read,
  output logic                    s_write,
  input  logic [DATA_WIDTH-1:0]   s_readdata,
  input  logic                    s_waitrequest,
  output logic                    arb_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   req0;
  logic   req1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Grant state and round-robin history
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == GNT0) begin
        last_grant <= 1'b0;
      end else if (state == IDLE && state_next == GNT1) begin
        last_grant <= 1'b1;
      end
    end
  end

  // Next-state selection and slave/master routing
  always_comb begin
    state_next     = IDLE;
    s_address      = '0;
    s_byteenable   = '0;
    s_writedata    = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = '0;
    m1_readdata    = '0;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          // On a tie, round-robin favours the master that was not served last
          if ((ROUND_ROBIN != 0) && !last_grant) begin
            state_next = GNT1;
          end else begin
            state_next = GNT0;
          end
        end else if (req0) begin
          state_next = GNT0;
        end else if (req1) begin
          state_next = GNT1;
        end else begin
          state_next = IDLE;
        end
      end
      GNT0: begin
        if (req0) begin
          s_address      = m0_address;
          s_byteenable   = m0_byteenable;
          s_writedata    = m0_writedata;
          s_read         = m0_read;
          s_write        = m0_write;
          m0_waitrequest = s_waitrequest;
          m0_readdata    = s_readdata;
          state_next     = s_waitrequest ? GNT0 : IDLE;
        end else begin
          state_next = IDLE;
        end
      end
      GNT1: begin
        if (req1) begin
          s_address      = m1_address;
          s_byteenable   = m1_byteenable;
          s_writedata    = m1_writedata;
          s_read         = m1_read;
          s_write        = m1_write;
          m1_waitrequest = s_waitrequest;
          m1_readdata    = s_readdata;
          state_next     = s_waitrequest ? GNT1 : IDLE;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef AVL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] T_MAX    = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] T_MAX_M1 = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wait_cnt;
  logic          timeout_flag;

  // Stall watchdog: counter is cleared in IDLE, so every grant starts from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else if (state == IDLE) begin
      wait_cnt <= '0;
    end else if (s_waitrequest) begin
      if (wait_cnt != T_MAX) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (wait_cnt == T_MAX_M1) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  assign arb_timeout = timeout_flag;
`else
  assign arb_timeout = 1'b0;
`endif

endmodule

// File: doc/avl_arbiter_2m.md
Name: avl_arbiter_2m

Overview:
- Two-master to one-slave Avalon-MM arbiter.
- Lets the instruction-side and data-side Avalon masters share a single Avalon memory slave such as avl_slave_mem_dbg.
- Sits between the bus-interface masters and the memory slave.
- Registered grant FSM with round-robin or fixed priority; waitrequest-based handshake passed through to the granted master.

Parameters:
ADDR_WIDTH, 32, address width of all Avalon ports
DATA_WIDTH, 32, data width; byteenable width BE_W = DATA_WIDTH/8
ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority (m0 always wins)
TIMEOUT_CYCLES, 1000, watchdog limit (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
m0_address  in  ADDR_WIDTH  master 0 (instruction) address
m0_byteenable  in  BE_W  master 0 byte enables
m0_writedata  in  DATA_WIDTH  master 0 write data
m0_read  in  1  master 0 read request
m0_write  in  1  master 0 write request
m0_readdata  out  DATA_WIDTH  read data to master 0
m0_waitrequest  out  1  stall to master 0
m1_address, m1_byteenable, m1_writedata, m1_read, m1_write, m1_readdata, m1_waitrequest: same as m0_*, for master 1 (data)
s_address  out  ADDR_WIDTH  to slave
s_byteenable  out  BE_W  to slave
s_writedata  out  DATA_WIDTH  to slave
s_read  out  1  to slave
s_write  out  1  to slave
s_readdata  in  DATA_WIDTH  from slave
s_waitrequest  in  1  from slave
arb_timeout  out  1  sticky watchdog flag

Behaviour:
- Request: req_i = mi_read | mi_write. Masters hold address, data and strobes until they see waitrequest low.
- FSM states: IDLE, GNT0, GNT1; state is registered.
- Reset: state=IDLE, last_grant=1 (so m0 wins the first tie), arb_timeout=0.
- IDLE transitions:
  - no request -> IDLE.
  - only req_0 -> GNT0; only req_1 -> GNT1.
  - both requesting, ROUND_ROBIN=1 -> grant the master != last_grant.
  - both requesting, ROUND_ROBIN=0 -> GNT0.
  - On entering GNTi, last_grant <= i.
- GNTi outputs:
  - s_* driven from mi_* combinationally.
  - mi_waitrequest = s_waitrequest; mi_readdata = s_readdata.
  - The other master: waitrequest=1, readdata=0.
- IDLE outputs: s_read=s_write=0; s_address, s_byteenable, s_writedata = 0; both waitrequests=1; readdata=0.
- Completion: in GNTi, (req_i & !s_waitrequest) completes the transfer; next state IDLE.
  - Read data is valid in the completion cycle (zero read latency).
- Latency:
  - Arbitration costs 1 cycle; minimum transfer = 2 cycles (IDLE→grant, grant with waitrequest low).
  - 1 dead IDLE cycle between back-to-back transfers.
- Granted master drops its request before completion (protocol violation): next state IDLE, nothing forwarded in that cycle.
- Read and write both high: forwarded unchanged; the slave defines the result.
- Reset mid-transfer: state IDLE at the next edge; s_read/s_write low from then on; any pending transfer is abandoned.
- Non-granted master's request is never forwarded and never lost; it remains pending until granted.

Optional Feature:
- Macro: AVL_ARB_TIMEOUT_EN.
- Enabled:
  - wait_cnt (clog2(TIMEOUT_CYCLES+1) bits) clears on entering GNT0/GNT1 and increments each GNT cycle with s_waitrequest=1.
  - When wait_cnt reaches TIMEOUT_CYCLES, arb_timeout is set.
  - arb_timeout is sticky until rst; no abort, the transfer continues.
- Disabled: no counter; arb_timeout tied 0.

Test Plan:
- Reset values: hold rst 2 cycles with m0_read=1 -> s_read=0, m0_waitrequest=1, m1_waitrequest=1, arb_timeout=0; after release, s_read=1 with s_address=m0_address one cycle later.
- m0 read of 0xBFC00000, slave waitrequest high 2 cycles then low with s_readdata=0x12345678 -> m0_readdata=0x12345678 in the completion cycle; total 4 cycles from request; m1_waitrequest=1 throughout.
- m1 write of 0x12ABCDEF to 0x00000AFC with byteenable 4'b0011 -> s_write=1, s_address=0x00000AFC, s_byteenable=4'b0011, s_writedata=0x12ABCDEF; slave word updates only the low 2 bytes.
- ROUND_ROBIN=1, both masters continuously requesting, slave waitrequest=0 -> grant sequence GNT0, IDLE, GNT1, IDLE, GNT0…; 3 transfers each in 12 cycles.
- ROUND_ROBIN=0, same stimulus -> only m0 completes transfers; m1_waitrequest stays 1.
- AVL_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave waitrequest stuck high -> arb_timeout rises after 8 stalled GNT cycles and stays 1 after waitrequest drops, until rst.
